floating_point_activation_stream: RTL and testbench

FLOATING_POINT_ACTIVATION_STREAM -- requirements
Module: floating_point_activation_stream

---
 rtl/floating_point_activation_stream.sv | 253 +++++++++++++++++++++++++
 tb/tb_floating_point_activation_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_activation_stream.sv
`default_nettype none
// ============================================================================
// Module      : floating_point_activation_stream (+ fp_sigmoid_core)
// Description : Streaming IEEE-754 sigmoid activation. One operand register
//               (S1), a result-select stage with special-case handling, and
//               a credit-protected output FIFO.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - input handshake
//               in_data             - operand word
//               sigmoid_enable      - per-word mode (1 = sigmoid, 0 = bypass)
//               out_valid/out_ready - output handshake
//               out_data            - result word at FIFO head
//               out_special         - head came from a special-case path
//               nan_count           - saturating count of NaN sigmoid operands
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fp_sigmoid_core: combinational piecewise-linear sigmoid for normal operands.
//   |x| >= 5         : 1
//   2.375 <= |x| < 5 : |x|/32 + 0.84375
//   1 <= |x| < 2.375 : |x|/8  + 0.625
//   |x| < 1          : |x|/4  + 0.5
//   x < 0            : 1 - f(|x|)
// Evaluated in fixed point with M fraction bits, then renormalised.
// ----------------------------------------------------------------------------
module fp_sigmoid_core #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 23,
    parameter int E          = 8
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] y
);
    localparam int c_fw   = M + 3;              // 3 integer bits cover |x| < 8
    localparam int c_pw   = $clog2(M + 4);
    localparam int c_bias = (1 << (E - 1)) - 1;
    localparam logic [E-1:0]    c_e_bias = E'(c_bias);
    localparam logic [E-1:0]    c_e_sat  = E'(c_bias + 3);
    localparam logic [c_fw-1:0] c_one    = c_fw'(1)  << M;
    localparam logic [c_fw-1:0] c_five   = c_fw'(5)  << M;
    localparam logic [c_fw-1:0] c_x2375  = c_fw'(19) << (M - 3);
    localparam logic [c_fw-1:0] c_k84    = c_fw'(27) << (M - 5);
    localparam logic [c_fw-1:0] c_k625   = c_fw'(5)  << (M - 3);
    localparam logic [c_fw-1:0] c_half   = c_fw'(1)  << (M - 1);

    logic            w_sign;
    logic [E-1:0]    w_exp;
    logic [M:0]      w_sig;
    logic            w_sat;
    logic [c_fw-1:0] w_fx;
    logic [c_fw-1:0] w_yp;
    logic [c_fw-1:0] w_y;
    logic [c_pw-1:0] w_lead;
    logic            w_nz;
    logic [E-1:0]    w_e_out;
    logic [M-1:0]    w_mant;

    assign w_sign = x[DATA_WIDTH-1];
    assign w_exp  = x[DATA_WIDTH-2 -: E];
    assign w_sig  = {1'b1, x[M-1:0]};

    // Magnitude to fixed point; anything >= 8 is deep in saturation.
    always_comb begin
        w_sat = 1'b0;
        w_fx  = '0;
        if (w_exp >= c_e_sat) begin
            w_sat = 1'b1;
        end else if (w_exp >= c_e_bias) begin
            w_fx = {2'b00, w_sig} << (w_exp - c_e_bias);
        end else begin
            w_fx = {2'b00, w_sig} >> (c_e_bias - w_exp);
        end
    end

    always_comb begin
        if (w_sat || (w_fx >= c_five)) begin
            w_yp = c_one;
        end else if (w_fx >= c_x2375) begin
            w_yp = (w_fx >> 5) + c_k84;
        end else if (w_fx >= c_one) begin
            w_yp = (w_fx >> 3) + c_k625;
        end else begin
            w_yp = (w_fx >> 2) + c_half;
        end
    end

    assign w_y = w_sign ? (c_one - w_yp) : w_yp;

    // Leading-one search; w_y <= 1.0 so the lead never sits above bit M.
    always_comb begin
        w_lead = '0;
        w_nz   = 1'b0;
        for (int i = 0; i < c_fw; i++) begin
            if (w_y[i]) begin
                w_lead = c_pw'(i);
                w_nz   = 1'b1;
            end
        end
    end

    assign w_e_out = E'(c_bias - M) + E'(w_lead);
    assign w_mant  = M'(w_y << (c_pw'(M) - w_lead));

    always_comb begin
        y = x;
        if (enable) begin
            y = w_nz ? {1'b0, w_e_out, w_mant} : '0;
        end
    end
endmodule

module floating_point_activation_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 23,
    parameter int E          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  sigmoid_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_special,
    output logic [7:0]            nan_count
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [E-1:0]          c_exp_ones = '1;
    localparam logic [E-1:0]          c_exp_bias = E'((1 << (E - 1)) - 1);
    localparam logic [DATA_WIDTH-1:0] c_qnan = {1'b0, c_exp_ones, 1'b1, {(M-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_one  = {1'b0, c_exp_bias, {M{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_half = {1'b0, c_exp_bias - E'(1), {M{1'b0}}};
    localparam logic [c_aw-1:0]       c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0]       c_cnt_one = c_cw'(1);
    localparam logic [c_cw:0]         c_depth   = (c_cw + 1)'(FIFO_DEPTH);

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_en;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];   // {result, special}
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_cw-1:0]       r_count;
    logic [7:0]            r_nan_count;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sign;
    logic [E-1:0]          w_exp;
    logic [M-1:0]          w_man;
    logic                  w_is_nan;
    logic                  w_is_inf;
    logic                  w_is_zero;
    logic [DATA_WIDTH-1:0] w_sig_y;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_special;
    logic [DATA_WIDTH:0]   w_head;

    // Credit check counts the word sitting in S1, so S1 can always drain.
    assign in_ready  = ({1'b0, r_count} + {{c_cw{1'b0}}, r_s1_valid}) < c_depth;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = r_s1_valid;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    assign w_sign    = r_s1_data[DATA_WIDTH-1];
    assign w_exp     = r_s1_data[DATA_WIDTH-2 -: E];
    assign w_man     = r_s1_data[M-1:0];
    assign w_is_nan  = (w_exp == c_exp_ones) && (w_man != '0);
    assign w_is_inf  = (w_exp == c_exp_ones) && (w_man == '0);
    assign w_is_zero = (w_exp == '0);

    fp_sigmoid_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .M          (M),
        .E          (E)
    ) u_sigmoid (
        .x      (r_s1_data),
        .enable (1'b1),
        .y      (w_sig_y)
    );

    always_comb begin
        w_result  = r_s1_data;
        w_special = 1'b0;
        if (r_s1_en) begin
            if (w_is_nan) begin
                w_result  = c_qnan;
                w_special = 1'b1;
            end else if (w_is_inf) begin
                w_result  = w_sign ? '0 : c_one;
                w_special = 1'b1;
            end else if (w_is_zero) begin
                w_result  = c_half;
                w_special = 1'b1;
            end else begin
                w_result  = w_sig_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_en     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_nan_count <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_en   <= sigmoid_enable;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_push && r_s1_en && w_is_nan && (r_nan_count != 8'hFF)) begin
                r_nan_count <= r_nan_count + 8'd1;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_result, w_special};
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_data    = out_valid ? w_head[DATA_WIDTH:1] : '0;
    assign out_special = out_valid ? w_head[0] : 1'b0;
    assign nan_count   = r_nan_count;
endmodule
`default_nettype wire

// File: tb/tb_floating_point_activation_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_floating_point_activation_stream
// Description : Directed self-checking bench for the activation stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_activation_stream;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sigmoid_enable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_special;
    logic [7:0]  nan_count;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];

    floating_point_activation_stream #(
        .DATA_WIDTH (32),
        .M          (23),
        .E          (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .sigmoid_enable (sigmoid_enable),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_special    (out_special),
        .nan_count      (nan_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // One word through an empty pipe: invisible after edge N, at head after N+1.
    task automatic send_one(input string tag, input logic [31:0] d, input logic en,
                            input logic [31:0] exp_d, input logic exp_s);
        in_valid       = 1'b1;
        in_data        = d;
        sigmoid_enable = en;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid_n1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid_n2"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_special"}, {31'd0, out_special}, {31'd0, exp_s});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_popped"}, {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] fill_word(input int k);
        return 32'hA5A5_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] stream_word(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    initial begin
        int   accepted;
        int   nxt;
        logic acc;

        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        sigmoid_enable = 1'b0;
        out_ready      = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_special", {31'd0, out_special}, 32'd0);
        chk("rst_nan_count", {24'd0, nan_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Special-case paths and bypass
        send_one("neg_zero", 32'h8000_0000, 1'b1, 32'h3F00_0000, 1'b1);
        send_one("pos_zero", 32'h0000_0000, 1'b1, 32'h3F00_0000, 1'b1);
        send_one("subnormal", 32'h0000_0001, 1'b1, 32'h3F00_0000, 1'b1);
        send_one("pos_inf", 32'h7F80_0000, 1'b1, 32'h3F80_0000, 1'b1);
        send_one("neg_inf", 32'hFF80_0000, 1'b1, 32'h0000_0000, 1'b1);
        chk("nan_count_before", {24'd0, nan_count}, 32'd0);
        send_one("nan", 32'h7F80_0001, 1'b1, 32'h7FC0_0000, 1'b1);
        chk("nan_count_after", {24'd0, nan_count}, 32'd1);
        send_one("bypass_pi", 32'h4049_0FDB, 1'b0, 32'h4049_0FDB, 1'b0);
        send_one("bypass_nan", 32'h7F80_0001, 1'b0, 32'h7F80_0001, 1'b0);
        chk("nan_count_bypass", {24'd0, nan_count}, 32'd1);
        send_one("neg_qnan", 32'hFFC0_0000, 1'b1, 32'h7FC0_0000, 1'b1);
        chk("nan_count_two", {24'd0, nan_count}, 32'd2);
        // sigmoid(100.0) rounds to exactly 1.0 in single precision
        send_one("normal_100", 32'h42C8_0000, 1'b1, 32'h3F80_0000, 1'b0);

        // Back-pressure: fill with out_ready low
        accepted       = 0;
        in_valid       = 1'b1;
        sigmoid_enable = 1'b0;
        in_data        = fill_word(0);
        for (int c = 0; c < 10; c++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) accepted++;
            in_data = fill_word(accepted);
        end
        chk("fill_accepted", 32'(accepted), 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_data", out_data, fill_word(i));
            @(negedge clk);
        end
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Steady state: two words held, then simultaneous push/pop
        exp_q.delete();
        in_valid = 1'b1;
        in_data  = stream_word(0);
        exp_q.push_back(stream_word(0));
        @(negedge clk);
        in_data = stream_word(1);
        exp_q.push_back(stream_word(1));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        nxt       = 2;
        for (int c = 0; c < 20; c++) begin
            in_data = stream_word(nxt);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            acc = in_ready;
            if (acc) exp_q.push_back(stream_word(nxt));
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stream_underflow", 32'd1, 32'd0);
                else chk("stream_order", out_data, exp_q.pop_front());
            end
            @(negedge clk);
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stream_extra", out_data, 32'd0);
                else chk("stream_tail", out_data, exp_q.pop_front());
            end
            @(negedge clk);
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // nan_count saturation: 300 NaNs streamed from a count of 2
        sigmoid_enable = 1'b1;
        in_data        = 32'h7F80_0001;
        in_valid       = 1'b1;
        for (int c = 0; c < 300; c++) @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("nan_saturate", {24'd0, nan_count}, 32'd255);
        chk("nan_sat_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset with three words in flight
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_nan_count", {24'd0, nan_count}, 32'd0);
        chk("async_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        send_one("post_rst_first", 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
